axistream_capture: RTL and testbench



---
 rtl/axistream_capture.sv | 150 +++++++++++++++
 tb/tb_axistream_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axistream_capture.sv
// axistream_capture: AXI-Stream sink storing whole packets in a circular beat buffer with a descriptor FIFO
// Ports:
//   axi_aclk, axi_aresetn            clock, asynchronous active-low reset
//   TDATA, TVALID, TLAST, TREADY     stream slave (one beat = one buffer word)
//   rd_en, rd_addr, rd_data          registered buffer read port (data one cycle after rd_en)
//   desc_valid, desc_start, desc_len first-word-fall-through head descriptor
//   desc_pop                         consume head descriptor and free its beats
//   pkt_count, drop_count, overflow  committed packets, dropped packets (saturating), sticky drop flag
// Build option: define AXISTREAM_CAPTURE_THROTTLE_EN to gate TREADY with a 16-bit Galois LFSR.
module axistream_capture #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 8,
  parameter int DESC_DEPTH_LOG = 4
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [DATA_WIDTH-1:0] TDATA,
  input  logic                  TVALID,
  input  logic                  TLAST,
  output logic                  TREADY,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  desc_valid,
  output logic [ADDR_WIDTH-1:0] desc_start,
  output logic [ADDR_WIDTH:0]   desc_len,
  input  logic                  desc_pop,
  output logic [31:0]           pkt_count,
  output logic [15:0]           drop_count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DD    = 1 << DESC_DEPTH_LOG;
  localparam logic [ADDR_WIDTH+1:0]   DEPTH_W = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [DESC_DEPTH_LOG:0] DD_W    = {1'b1, {DESC_DEPTH_LOG{1'b0}}};
  localparam logic [DESC_DEPTH_LOG:0] D_ONE   = {{DESC_DEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]     LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]   PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_dstart [DD];
  logic [ADDR_WIDTH:0]     r_dlen [DD];
  logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_pkt_start, w_wr_ptr_nxt, w_start;
  logic [ADDR_WIDTH:0]     r_used, r_cur_len, w_cur_len_nxt, w_len, w_hlen;
  logic [DESC_DEPTH_LOG:0] r_dwp, r_drp, w_dcount;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [31:0]             r_pkt_count;
  logic [15:0]             r_drop_count;
  logic                    r_overflow, r_rdy;
  logic                    w_accept, w_fits, w_pop, w_dfull, w_wr, w_push, w_drop;

`ifdef AXISTREAM_CAPTURE_THROTTLE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) r_lfsr <= 16'hACE1;
    else              r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign TREADY = r_rdy & r_lfsr[0];
`else
  assign TREADY = r_rdy;
`endif

  assign w_accept   = TVALID && TREADY;
  // The packet's first beat address: wr_ptr while idle, latched start otherwise
  assign w_start    = (r_state == IDLE) ? r_wr_ptr : r_pkt_start;
  assign w_len      = r_cur_len + LEN_ONE;
  // used + cur_len + 1 <= depth, i.e. the incoming beat still has a free slot
  assign w_fits     = ({1'b0, r_used} + {1'b0, r_cur_len}) < DEPTH_W;
  assign w_dcount   = r_dwp - r_drp;
  assign desc_valid = w_dcount != '0;
  assign w_pop      = desc_pop && desc_valid;
  // A pop in the same cycle makes room for the push
  assign w_dfull    = (w_dcount == DD_W) && !w_pop;
  assign w_hlen     = r_dlen[r_drp[DESC_DEPTH_LOG-1:0]];
  assign desc_start = desc_valid ? r_dstart[r_drp[DESC_DEPTH_LOG-1:0]] : '0;
  assign desc_len   = desc_valid ? w_hlen : '0;
  assign rd_data    = r_rd_data;
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_cur_len_nxt = r_cur_len;
    w_wr          = 1'b0;
    w_push        = 1'b0;
    w_drop        = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE, RECV: begin
          if (!w_fits || (TLAST && w_dfull)) begin
            w_drop        = 1'b1;
            w_wr_ptr_nxt  = w_start;
            w_cur_len_nxt = '0;
            w_state_nxt   = TLAST ? IDLE : DROP;
          end else begin
            w_wr          = 1'b1;
            w_push        = TLAST;
            w_wr_ptr_nxt  = r_wr_ptr + PTR_ONE;
            w_cur_len_nxt = TLAST ? '0 : w_len;
            w_state_nxt   = TLAST ? IDLE : RECV;
          end
        end
        default: w_state_nxt = TLAST ? IDLE : DROP;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= TDATA;
    if (w_push) begin
      r_dstart[r_dwp[DESC_DEPTH_LOG-1:0]] <= w_start;
      r_dlen[r_dwp[DESC_DEPTH_LOG-1:0]]   <= w_len;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      r_rdy        <= 1'b0;
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_pkt_start  <= '0;
      r_cur_len    <= '0;
      r_used       <= '0;
      r_dwp        <= '0;
      r_drp        <= '0;
      r_rd_data    <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_rdy       <= 1'b1;
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_pkt_start <= w_start;
      r_cur_len   <= w_cur_len_nxt;
      r_used      <= r_used + (w_push ? w_len : '0) - (w_pop ? w_hlen : '0);
      if (w_push) r_dwp <= r_dwp + D_ONE;
      if (w_pop) r_drp <= r_drp + D_ONE;
      if (w_push) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_drop) begin
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        r_overflow <= 1'b1;
      end
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
endmodule

// File: tb/tb_axistream_capture.sv
// tb_axistream_capture: randomized packet traffic against a queue-based model of the capture buffer
module tb_axistream_capture;
  localparam int DW = 32, AW = 5, DL = 4, DEPTH = 32, DD = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          desc_valid, desc_pop = 1'b0;
  logic [AW-1:0] desc_start;
  logic [AW:0]   desc_len;
  logic [31:0]   pkt_count;
  logic [15:0]   drop_count;
  logic          overflow;

  always #5 clk = ~clk;

  axistream_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESC_DEPTH_LOG(DL)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .TDATA(tdata), .TVALID(tvalid), .TLAST(tlast), .TREADY(tready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .desc_valid(desc_valid), .desc_start(desc_start), .desc_len(desc_len), .desc_pop(desc_pop),
    .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
  );

  typedef struct {int start; int len;} desc_t;
  desc_t         m_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wp, m_pkts, m_drops;
  bit            m_ovf;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; desc_pop = 1'b0; rd_en = 1'b0;
    #2;
    chk("rst_tready", tready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_start", desc_start, 0);
    chk("rst_desc_len", desc_len, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    m_q.delete(); m_wp = 0; m_pkts = 0; m_drops = 0; m_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifndef AXISTREAM_CAPTURE_THROTTLE_EN
    chk("tready_up", tready, 1);
`endif
  endtask

  task automatic send_beat(logic [DW-1:0] d, bit last, bit pop);
    int n = 0;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = last; desc_pop = 1'b0;
    while (!tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tready) chk("tready_timeout", tready, 1);
    desc_pop = pop;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; desc_pop = 1'b0;
  endtask

  task automatic check_state(string tag);
    @(negedge clk);
    chk({tag, "_pkt_count"}, pkt_count, m_pkts);
    chk({tag, "_drop_count"}, drop_count, m_drops);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_desc_valid"}, desc_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk({tag, "_desc_start"}, desc_start, m_q[0].start);
      chk({tag, "_desc_len"}, desc_len, m_q[0].len);
    end
  endtask

  // Outcome is decided from free space and descriptor count seen before the packet starts
  task automatic send_pkt(int n, bit pop_last, bit rnd);
    logic [DW-1:0] d[$];
    desc_t tmp;
    int u = 0, drop_at = 0;
    bit commit;
    foreach (m_q[i]) u += m_q[i].len;
    for (int k = 1; k <= n; k++) begin
      d.push_back(rnd ? DW'($urandom) : DW'(k));
      if (drop_at == 0 && u + k > DEPTH) drop_at = k;
    end
    commit = (drop_at == 0) && !(m_q.size() == DD && !pop_last);
    for (int k = 0; k < n; k++) send_beat(d[k], k == n - 1, pop_last && k == n - 1);
    if (pop_last && m_q.size() != 0) tmp = m_q.pop_front();
    if (commit) begin
      for (int k = 0; k < n; k++) m_mem[(m_wp + k) % DEPTH] = d[k];
      m_q.push_back('{m_wp, n});
      m_wp = (m_wp + n) % DEPTH;
      m_pkts++;
    end else begin
      if (m_drops < 65535) m_drops++;
      m_ovf = 1'b1;
    end
    check_state("pkt");
  endtask

  task automatic pop_check();
    desc_t h;
    @(negedge clk);
    chk("pop_valid", desc_valid, m_q.size() != 0);
    if (m_q.size() == 0) return;
    h = m_q.pop_front();
    chk("pop_start", desc_start, h.start);
    chk("pop_len", desc_len, h.len);
    for (int k = 0; k < h.len; k++) begin
      @(negedge clk);
      rd_en = 1'b1; rd_addr = AW'((h.start + k) % DEPTH);
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk("rd_data", rd_data, m_mem[(h.start + k) % DEPTH]);
    end
    @(negedge clk);
    desc_pop = 1'b1;
    @(posedge clk); #1;
    desc_pop = 1'b0;
  endtask

  initial begin
    do_reset();

    send_pkt(1, 0, 0);
    chk("single_start", desc_start, 0);
    chk("single_len", desc_len, 1);
    chk("single_pkts", pkt_count, 1);
    pop_check();
    chk("single_rd", rd_data, 1);
    @(posedge clk); #1;
    chk("rd_hold", rd_data, 1);

    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(4, 0, 1);
    chk("b2b_pkts", pkt_count, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_start", desc_start, 4 * i);
      pop_check();
    end

    do_reset();
    for (int i = 0; i < 7; i++) send_pkt(4, 0, 1);
    send_pkt(6, 0, 1);
    chk("ovf_drops", drop_count, 1);
    chk("ovf_flag", overflow, 1);
    pop_check();
    send_pkt(6, 0, 1);
    for (int i = 0; i < 6; i++) pop_check();
    @(negedge clk);
    chk("wrap_start", desc_start, 28);
    chk("wrap_len", desc_len, 6);
    pop_check();

    do_reset();
    for (int i = 0; i < 16; i++) send_pkt(1, 0, 1);
    send_pkt(1, 0, 1);
    chk("full_drops", drop_count, 1);
    send_pkt(1, 1, 1);
    chk("full_pushpop_pkts", pkt_count, 17);
    for (int i = 0; i < 16; i++) pop_check();
    @(negedge clk);
    chk("full_drained", desc_valid, 0);

    do_reset();
    send_beat(32'hAAAA_0001, 0, 0);
    send_beat(32'hAAAA_0002, 0, 0);
    do_reset();
    send_pkt(3, 0, 1);
    chk("midrst_start", desc_start, 0);
    chk("midrst_len", desc_len, 3);
    pop_check();

    do_reset();
    for (int i = 0; i < 150; i++) begin
      send_pkt($urandom_range(1, 8), $urandom_range(0, 3) == 0, 1);
      if ($urandom_range(0, 1) == 1) pop_check();
    end
    while (m_q.size() != 0) pop_check();
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
